// File: rtl/demux2_buf.sv
// Routes each input word to one of two independent 2-entry FIFOs chosen by s.
// Latency 1 cycle to the head of an empty queue; in_ready reflects only the selected queue's fill.
module demux2_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             s,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y1,
    output logic             y1_valid,
    input  logic             y1_ready
);
    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [WIDTH-1:0] mem_q [2][2];
    logic [1:0]       cnt_q  [2];
    logic [1:0]       cnt_d  [2];
    logic             rptr_q [2];
    logic             rptr_d [2];
    logic             wptr_q [2];
    logic             wptr_d [2];
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       out_rdy;

    assign out_rdy = {y1_ready, y0_ready};

    // Consumer readies deliberately do not feed in_ready: a full queue stalls even if it drains this edge.
    assign in_ready = (cnt_q[s] < FULL);

    assign y0_valid = (cnt_q[0] != 2'd0);
    assign y1_valid = (cnt_q[1] != 2'd0);
    assign y0       = y0_valid ? mem_q[0][rptr_q[0]] : '0;
    assign y1       = y1_valid ? mem_q[1][rptr_q[1]] : '0;

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            push[c]   = in_valid && in_ready && (s == 1'(c));
            pop[c]    = (cnt_q[c] != 2'd0) && out_rdy[c];
            cnt_d[c]  = cnt_q[c] + {1'b0, push[c]} - {1'b0, pop[c]};
            wptr_d[c] = wptr_q[c] ^ push[c];
            rptr_d[c] = rptr_q[c] ^ pop[c];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                cnt_q[c]  <= '0;
                rptr_q[c] <= 1'b0;
                wptr_q[c] <= 1'b0;
                for (int e = 0; e < 2; e++) begin
                    mem_q[c][e] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                cnt_q[c]  <= cnt_d[c];
                rptr_q[c] <= rptr_d[c];
                wptr_q[c] <= wptr_d[c];
                if (push[c]) begin
                    mem_q[c][wptr_q[c]] <= d;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux2_buf.sv
// Bench for demux2_buf: queue-based reference model plus directed literal scenarios and random traffic.
module tb_demux2_buf;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] d;
    logic        s;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y0, y1;
    logic        y0_valid, y1_valid;
    logic        y0_ready, y1_ready;

    int total = 0;
    int bad   = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];

    demux2_buf #(.WIDTH(32), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .d(d), .s(s), .in_valid(in_valid), .in_ready(in_ready),
        .y0(y0), .y0_valid(y0_valid), .y0_ready(y0_ready),
        .y1(y1), .y1_valid(y1_valid), .y1_ready(y1_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a queue per channel; a pop frees its slot before the push lands.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            bit pp0, pp1, ps0, ps1;
            pp0 = y0_ready && (q0.size() != 0);
            pp1 = y1_ready && (q1.size() != 0);
            ps0 = in_valid && !s && (q0.size() < 2);
            ps1 = in_valid &&  s && (q1.size() < 2);
            if (pp0) void'(q0.pop_front());
            if (pp1) void'(q1.pop_front());
            if (ps0) q0.push_back(d);
            if (ps1) q1.push_back(d);
        end
    end

    always @(negedge clk) begin
        chk("m_y0_valid", {31'd0, y0_valid}, {31'd0, q0.size() != 0});
        chk("m_y1_valid", {31'd0, y1_valid}, {31'd0, q1.size() != 0});
        chk("m_y0", y0, (q0.size() != 0) ? q0[0] : 32'd0);
        chk("m_y1", y1, (q1.size() != 0) ? q1[0] : 32'd0);
        chk("m_in_ready", {31'd0, in_ready},
            {31'd0, (s ? q1.size() : q0.size()) < 2});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic ch, input logic [31:0] w);
        s = ch; d = w; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; d = '0; s = 1'b0; in_valid = 1'b0; y0_ready = 1'b0; y1_ready = 1'b0;
        tick(); tick();
        chk("rst_y0_valid", {31'd0, y0_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        tick();

        // Route and latency
        push1(1'b0, 32'h00009248);
        chk("lat_y0", y0, 32'h00009248);
        chk("lat_y0_valid", {31'd0, y0_valid}, 32'd1);
        chk("lat_y1_valid", {31'd0, y1_valid}, 32'd0);
        chk("lat_y1", y1, 32'd0);

        // Fill and backpressure on channel 1
        push1(1'b1, 32'hA);
        push1(1'b1, 32'hB);
        s = 1'b1; #1;
        chk("bp_full_rdy", {31'd0, in_ready}, 32'd0);
        s = 1'b0; #1;
        chk("bp_other_rdy", {31'd0, in_ready}, 32'd1);
        push1(1'b1, 32'hC);
        chk("bp_head_a", y1, 32'hA);
        y1_ready = 1'b1;
        tick();
        chk("bp_head_b", y1, 32'hB);
        tick();
        chk("bp_drained", {31'd0, y1_valid}, 32'd0);
        y1_ready = 1'b0;
        y0_ready = 1'b1; tick(); y0_ready = 1'b0;

        // Ready without valid
        y0_ready = 1'b1;
        tick(); tick(); tick();
        chk("rnv_empty", {31'd0, y0_valid}, 32'd0);
        push1(1'b0, 32'h77);
        chk("rnv_word", y0, 32'h77);
        tick();
        chk("rnv_one_only", {31'd0, y0_valid}, 32'd0);
        y0_ready = 1'b0;

        // Simultaneous push and pop at count 1
        push1(1'b0, 32'h1);
        y0_ready = 1'b1;
        push1(1'b0, 32'h2);
        chk("pp_head", y0, 32'h2);
        chk("pp_valid", {31'd0, y0_valid}, 32'd1);
        tick();
        chk("pp_count1", {31'd0, y0_valid}, 32'd0);
        y0_ready = 1'b0;

        // Cross-channel push/pop in one edge
        push1(1'b0, 32'h5);
        y0_ready = 1'b1;
        push1(1'b1, 32'h00009249);
        chk("x_y0_valid", {31'd0, y0_valid}, 32'd0);
        chk("x_y1", y1, 32'h00009249);
        chk("x_y1_valid", {31'd0, y1_valid}, 32'd1);
        y0_ready = 1'b0;
        y1_ready = 1'b1; tick(); y1_ready = 1'b0;

        // Asynchronous reset with both queues full
        push1(1'b0, 32'h10); push1(1'b0, 32'h11);
        push1(1'b1, 32'h20); push1(1'b1, 32'h21);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_y0_valid", {31'd0, y0_valid}, 32'd0);
        chk("ar_y1_valid", {31'd0, y1_valid}, 32'd0);
        chk("ar_y0", y0, 32'd0);
        chk("ar_y1", y1, 32'd0);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        reset = 1'b0;
        tick();
        chk("ar_after", {31'd0, y1_valid}, 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            s        = 1'($urandom_range(0, 1));
            d        = $urandom;
            y0_ready = ($urandom_range(0, 2) != 0);
            y1_ready = ($urandom_range(0, 3) == 0);
            tick();
        end
        in_valid = 1'b0; y0_ready = 1'b0; y1_ready = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux2_buf.md
DEMUX2_BUF -- requirements
Module: demux2_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data width of the input and both outputs.
REQ-002 SHALL have parameter DEPTH, fixed at 2, giving the entries per output queue; other values are not supported.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port d, input, WIDTH bits: input data word.
REQ-006 SHALL have port s, input, 1 bit: destination select; 0 routes to channel 0, 1 routes to channel 1.
REQ-007 SHALL have port in_valid, input, 1 bit: d and s are valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the selected channel can accept a word.
REQ-009 SHALL have port y0, output, WIDTH bits: channel 0 head data.
REQ-010 SHALL have port y0_valid, output, 1 bit: channel 0 holds at least one word.
REQ-011 SHALL have port y0_ready, input, 1 bit: channel 0 consumer accepts.
REQ-012 SHALL have ports y1, y1_valid and y1_ready, identical to y0, y0_valid and y0_ready, for channel 1.

Function
REQ-013 SHALL treat a transfer on any port as occurring only on a rising clk edge where valid and ready are both 1.
REQ-014 SHALL keep one independent 2-entry FIFO per channel, each with a count of 0..2, a read pointer and a write pointer that wrap modulo 2.
REQ-015 SHALL drive in_ready = (count[s] < 2) combinationally from s and the registered counts only; y0_ready and y1_ready SHALL NOT reach in_ready.
REQ-016 SHALL, on an input transfer, write d into FIFO s at its write pointer and advance that pointer; the other channel is untouched.
REQ-017 SHALL drive yN_valid = (countN != 0), and yN = FIFO N head entry when yN_valid is 1, else all zeros.
REQ-018 SHALL, on an output transfer on channel N, advance read pointer N.
REQ-019 SHALL have a latency of 1 cycle: a word accepted at edge k is visible on yN with yN_valid=1 immediately after edge k, if the FIFO was empty.
REQ-020 SHALL preserve arrival order within each channel; no ordering is defined between channels.
REQ-021 SHALL handle simultaneous push and pop on the same channel as follows: at count=1, count stays 1 and the pushed word becomes the head after the edge; at count=2, no push is possible (in_ready=0), so the pop proceeds and count becomes 1.
REQ-022 SHALL, when in_valid=1 and in_ready=0, accept nothing and leave all state unchanged; the source holds d and s.
REQ-023 SHALL allow a push to one channel and a pop from the other channel in the same cycle with no interaction.
REQ-024 SHALL ignore yN_ready while yN_valid=0 (no underflow, pointers unchanged).
REQ-025 SHALL NOT let a change of s while in_valid=0 alter any state.

Reset
REQ-026 SHALL, while reset=1 (asynchronously, without waiting for clk), clear both counts and all pointers to 0 and clear storage to 0; y0, y1, y0_valid and y1_valid SHALL then be 0 and in_ready SHALL be 1.
REQ-027 SHALL, on reset asserted mid-operation, discard all queued words with no partial transfer; the first edge after deassertion behaves as from empty.

Verification
REQ-028 SHALL cover route and latency: reset, then d=32'h00009248, s=0, in_valid=1 for one edge -> next cycle y0=32'h00009248, y0_valid=1, y1_valid=0, y1=0.
REQ-029 SHALL cover fill and backpressure: y1_ready=0, push 32'hA, 32'hB with s=1 -> in_ready=0 with s=1, and in_ready=1 with s=0; a third push with s=1 is not accepted; then y1_ready=1 -> y1 shows A then B, then y1_valid=0.
REQ-030 SHALL cover simultaneous push and pop: channel 0 holds 32'h1, y0_ready=1, push 32'h2 with s=0 -> after the edge count stays 1 and y0=32'h2.
REQ-031 SHALL cover a cross-channel cycle: channel 0 pops 32'h5 while 32'h00009249 is pushed to channel 1 in the same edge -> y0_valid=0, and y1=32'h00009249 with y1_valid=1.
REQ-032 SHALL cover asynchronous reset: both FIFOs full, reset asserted between edges -> y0_valid, y1_valid, y0 and y1 become 0 and in_ready becomes 1 before the next clk edge.
REQ-033 SHALL cover a ready without valid: y0_ready=1 with channel 0 empty for 3 cycles, then one push -> exactly one word appears, no spurious data.
